// File: rtl/edge_event_arbiter.sv
// Per-channel rising-edge capture with one-deep pending slots, granted round-robin onto a
// valid/ready event port. Define EDGE_ARB_BOTH_EDGES_EN to also capture falling edges (adds evt_pol).
module edge_event_arbiter #(
    parameter int unsigned  N_CH = 4,
    localparam int unsigned ID_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] in_edge,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [ID_W-1:0] evt_id,
`ifdef EDGE_ARB_BOTH_EDGES_EN
    output logic            evt_pol,
`endif
    output logic [N_CH-1:0] pending,
    output logic [N_CH-1:0] overflow,
    input  logic [N_CH-1:0] ovf_clr
);

    typedef enum logic [0:0] {StIdle, StPresent} state_e;

    state_e            r_state, w_state_d;
    logic [N_CH-1:0]   r_prev;
    logic [N_CH-1:0]   r_pending, w_pending_d;
    logic [N_CH-1:0]   r_overflow, w_overflow_d;
    logic [ID_W-1:0]   r_evt_id, w_evt_id_d;
    logic [ID_W-1:0]   r_last_grant, w_last_grant_d;

    logic [N_CH-1:0]   w_rise;
    logic [N_CH-1:0]   w_edge;
    logic [N_CH-1:0]   w_granted;
    logic [N_CH-1:0]   w_keep;
    logic [ID_W-1:0]   w_winner;
    logic              w_found;
    logic              w_load;

`ifdef EDGE_ARB_BOTH_EDGES_EN
    logic [N_CH-1:0]   r_pol, w_pol_d;
    logic              r_evt_pol, w_evt_pol_d;

    assign w_edge  = in_edge ^ r_prev;
    assign evt_pol = r_evt_pol;
`else
    assign w_edge  = w_rise;
`endif

    assign w_rise    = in_edge & ~r_prev;
    assign evt_valid = (r_state == StPresent);
    assign evt_id    = r_evt_id;
    assign pending   = r_pending;
    assign overflow  = r_overflow;
    assign w_load    = ~evt_valid | evt_ready;

    // Search starts just after the last grant and wraps, so the last winner has lowest priority.
    always_comb begin
        int unsigned idx;
        w_found  = 1'b0;
        w_winner = '0;
        for (int unsigned k = 1; k <= N_CH; k++) begin
            idx = (32'(r_last_grant) + k) % N_CH;
            if (!w_found && r_pending[idx]) begin
                w_found  = 1'b1;
                w_winner = ID_W'(idx);
            end
        end
    end

    always_comb begin
        w_granted      = '0;
        w_state_d      = r_state;
        w_evt_id_d     = r_evt_id;
        w_last_grant_d = r_last_grant;
`ifdef EDGE_ARB_BOTH_EDGES_EN
        w_evt_pol_d    = r_evt_pol;
`endif
        if (w_load) begin
            if (w_found) begin
                w_state_d      = StPresent;
                w_evt_id_d     = w_winner;
                w_last_grant_d = w_winner;
                w_granted      = {{(N_CH-1){1'b0}}, 1'b1} << w_winner;
`ifdef EDGE_ARB_BOTH_EDGES_EN
                w_evt_pol_d    = r_pol[w_winner];
`endif
            end else begin
                w_state_d = StIdle;
            end
        end
        // A slot freed by this cycle's grant can take a new edge; otherwise the edge is lost.
        w_keep       = r_pending & ~w_granted;
        w_pending_d  = w_keep | w_edge;
        w_overflow_d = (r_overflow & ~ovf_clr) | (w_edge & w_keep);
`ifdef EDGE_ARB_BOTH_EDGES_EN
        w_pol_d      = (r_pol & w_keep) | (w_rise & ~w_keep);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_prev       <= '0;
            r_pending    <= '0;
            r_overflow   <= '0;
            r_evt_id     <= '0;
            r_last_grant <= ID_W'(N_CH - 1);
        end else begin
            r_state      <= w_state_d;
            r_prev       <= in_edge;
            r_pending    <= w_pending_d;
            r_overflow   <= w_overflow_d;
            r_evt_id     <= w_evt_id_d;
            r_last_grant <= w_last_grant_d;
        end
    end

`ifdef EDGE_ARB_BOTH_EDGES_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pol     <= '0;
            r_evt_pol <= 1'b0;
        end else begin
            r_pol     <= w_pol_d;
            r_evt_pol <= w_evt_pol_d;
        end
    end
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter: a cycle-level reference model pushes expected grants,
// a negedge monitor pops them on each handshake; directed scenarios followed by random traffic.
module tb_edge_event_arbiter;

    localparam int N = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  in_edge = '0;
    logic          evt_valid;
    logic          evt_ready = 1'b0;
    logic [IW-1:0] evt_id;
    logic [N-1:0]  pending;
    logic [N-1:0]  overflow;
    logic [N-1:0]  ovf_clr = '0;
`ifdef EDGE_ARB_BOTH_EDGES_EN
    logic          evt_pol;
`endif

    int n_checks = 0;
    int n_fail = 0;

    edge_event_arbiter #(.N_CH(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_edge   (in_edge),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
`ifdef EDGE_ARB_BOTH_EDGES_EN
        .evt_pol   (evt_pol),
`endif
        .pending   (pending),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        bit pol;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: slots, sticky flags and a rotating priority pointer as plain arrays.
    bit m_prev[N];
    bit m_pend[N];
    bit m_pol[N];
    bit m_ovf[N];
    bit m_valid;
    int m_last;

    function automatic logic [N-1:0] pack(input bit a[N]);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = a[i];
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                m_prev[i] = 0; m_pend[i] = 0; m_pol[i] = 0; m_ovf[i] = 0;
            end
            m_valid = 0;
            m_last  = N - 1;
            exp_q.delete();
        end else begin
            bit load, found, rise, fall, ev;
            int w;
            exp_t e;
            load  = !m_valid || evt_ready;
            found = 0;
            w     = 0;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (!found && m_pend[c]) begin found = 1; w = c; end
            end
            if (load) begin
                if (found) begin
                    m_valid   = 1;
                    m_last    = w;
                    m_pend[w] = 0;
                    e.id  = w;
                    e.pol = m_pol[w];
                    exp_q.push_back(e);
                end else begin
                    m_valid = 0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (ovf_clr[i]) m_ovf[i] = 0;
                rise = in_edge[i] && !m_prev[i];
                fall = !in_edge[i] && m_prev[i];
`ifdef EDGE_ARB_BOTH_EDGES_EN
                ev = rise || fall;
`else
                ev = rise;
`endif
                if (ev) begin
                    if (m_pend[i]) m_ovf[i] = 1;
                    else begin m_pend[i] = 1; m_pol[i] = rise; end
                end
                m_prev[i] = in_edge[i];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: state compared every cycle, identity popped from the scoreboard on each accept.
    always @(negedge clk) begin
        check("sb_evt_valid", {31'd0, evt_valid}, {31'd0, m_valid});
        check("sb_pending", 32'(pending), 32'(pack(m_pend)));
        check("sb_overflow", 32'(overflow), 32'(pack(m_ovf)));
        if (reset && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_accept: got evt_id %0d expected no event", evt_id);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_evt_id", 32'(evt_id), 32'(e.id));
`ifdef EDGE_ARB_BOTH_EDGES_EN
                check("sb_evt_pol", {31'd0, evt_pol}, {31'd0, e.pol});
`endif
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        in_edge = '0;
        cyc(1);
        reset = 1'b1;
        cyc(1);
    endtask

    initial begin
        #1 reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(2);
        check("rst_valid", {31'd0, evt_valid}, 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_overflow", 32'(overflow), 0);

        // Latency: pending at t, presented at t+1.
        in_edge = 4'b0100;
        cyc(1);
        check("lat_pending_t", 32'(pending), 32'h4);
        check("lat_valid_t", {31'd0, evt_valid}, 0);
        cyc(1);
        check("lat_valid_t1", {31'd0, evt_valid}, 1);
        check("lat_id_t1", 32'(evt_id), 2);
        check("lat_pending_t1", 32'(pending), 0);
        evt_ready = 1'b1;
        cyc(1);
        check("lat_drain", {31'd0, evt_valid}, 0);

        // All four at once drain in order with no bubble.
        do_reset();
        in_edge = 4'b1111;
        cyc(1);
        check("all_pending", 32'(pending), 32'hf);
        for (int i = 0; i < N; i++) begin
            cyc(1);
            check("all_valid", {31'd0, evt_valid}, 1);
            check("all_id", 32'(evt_id), 32'(i));
        end
        cyc(1);
        check("all_done", {31'd0, evt_valid}, 0);

        // Fairness after a grant to channel 1.
        do_reset();
        evt_ready = 1'b0;
        in_edge   = 4'b0010;
        cyc(2);
        check("fair_id1", 32'(evt_id), 1);
        in_edge = 4'b1011;
        cyc(1);
        check("fair_pending", 32'(pending), 32'h9);
        evt_ready = 1'b1;
        cyc(1);
        check("fair_first", 32'(evt_id), 3);
        cyc(1);
        check("fair_second", 32'(evt_id), 0);
        check("fair_second_v", {31'd0, evt_valid}, 1);
        cyc(1);
        check("fair_done", {31'd0, evt_valid}, 0);

        // Backpressure hold, overflow and its clear.
        do_reset();
        evt_ready = 1'b0;
        in_edge   = 4'b0010;
        cyc(2);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("bp_hold_v", {31'd0, evt_valid}, 1);
            check("bp_hold_id", 32'(evt_id), 1);
        end
        in_edge = 4'b0000; cyc(1);
        in_edge = 4'b0010; cyc(1);
        check("bp_pend1", 32'(pending), 32'h2);
        check("bp_noovf", 32'(overflow), 0);
        in_edge = 4'b0000; cyc(1);
        in_edge = 4'b0010; cyc(1);
        check("bp_ovf", 32'(overflow), 32'h2);
        ovf_clr = 4'b0010; cyc(1);
        ovf_clr = 4'b0000;
        check("bp_ovf_clr", 32'(overflow), 0);
        evt_ready = 1'b1;
        cyc(1);
        check("bp_next_id", 32'(evt_id), 1);
        cyc(1);
        check("bp_done", {31'd0, evt_valid}, 0);

        // New edge on the channel being granted refills its slot without overflow.
        do_reset();
        evt_ready = 1'b0;
        in_edge = 4'b0001; cyc(2);
        in_edge = 4'b0000; cyc(1);
        in_edge = 4'b0001; cyc(1);
        check("gs_pend_before", 32'(pending), 32'h1);
        in_edge = 4'b0000; cyc(1);
        evt_ready = 1'b1;
        in_edge = 4'b0001; cyc(1);
        check("gs_pend_after", 32'(pending), 32'h1);
        check("gs_noovf", 32'(overflow), 0);
        check("gs_id", 32'(evt_id), 0);
        cyc(1);
        check("gs_second_v", {31'd0, evt_valid}, 1);
        check("gs_second_id", 32'(evt_id), 0);
        check("gs_second_pend", 32'(pending), 0);
        cyc(1);
        check("gs_done", {31'd0, evt_valid}, 0);

        // Reset mid-transfer discards everything immediately.
        do_reset();
        evt_ready = 1'b0;
        in_edge = 4'b0111; cyc(2);
        in_edge = 4'b0110; cyc(1);
        in_edge = 4'b0111; cyc(1);
        check("mr_pend", 32'(pending), 32'h7);
        check("mr_valid", {31'd0, evt_valid}, 1);
        reset = 1'b0;
        #1;
        check("mr_rst_valid", {31'd0, evt_valid}, 0);
        check("mr_rst_pend", 32'(pending), 0);
        check("mr_rst_ovf", 32'(overflow), 0);
        in_edge = 4'b1000;
        cyc(1);
        reset = 1'b1;
        cyc(1);
        check("mr_rel_pend", 32'(pending), 32'h8);
        cyc(1);
        check("mr_rel_id", 32'(evt_id), 3);
        check("mr_rel_valid", {31'd0, evt_valid}, 1);
        evt_ready = 1'b1;
        cyc(2);
        check("mr_single", {31'd0, evt_valid}, 0);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            in_edge   = in_edge ^ N'($urandom & $urandom);
            evt_ready = ($urandom_range(3) != 0);
            ovf_clr   = ($urandom_range(7) == 0) ? N'($urandom) : '0;
            reset     = ($urandom_range(149) != 0);
            cyc(1);
        end
        reset = 1'b1;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Collects rising-edge events from N_CH independent level inputs.
- Each input has its own edge detector (Mealy-style, one previous-value register per channel) and a one-deep pending flag.
- Pending events are granted round-robin onto a single valid/ready event port that carries the channel ID.
- Sits between raw synchronous status lines and a single event consumer, e.g. an interrupt/status sequencer.

Parameters:
- N_CH, 4, number of input channels (2..16). Derived localparam ID_W = $clog2(N_CH).

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-low reset
- in_edge  input  N_CH  level inputs, already synchronous to clk
- evt_valid  output  1  event present on evt_id
- evt_ready  input  1  consumer accepts event when evt_valid & evt_ready at posedge
- evt_id  output  ID_W  channel index of the presented event
- pending  output  N_CH  per-channel pending flags, not yet presented
- overflow  output  N_CH  sticky: an edge was lost because the channel was already pending
- ovf_clr  input  N_CH  synchronous clear of overflow bits, one bit per channel

Behaviour:
- Reset (reset=0, asynchronous):
  - prev, pending, overflow, evt_valid, evt_id all 0.
  - Round-robin pointer last_grant = N_CH-1, so channel 0 has first priority.
- prev is 0 after reset, so an input already high at reset release produces one event on the first posedge.
- Edge detection: edge[i] = in_edge[i] & ~prev[i], evaluated at each posedge; prev[i] <= in_edge[i] every cycle.
- Output FSM, two states:
  - IDLE: evt_valid=0.
  - PRESENT: evt_valid=1; evt_id and evt_valid hold stable until accepted.
- Load condition: load = ~evt_valid | evt_ready.
  - On a posedge with load and any pending bit set: winner = first set bit searching last_grant+1, last_grant+2, ... with modulo-N_CH wrap.
  - Then evt_id <= winner, evt_valid <= 1, pending[winner] cleared, last_grant <= winner.
  - On load with no pending bit set: evt_valid <= 0 (IDLE).
  - Back-to-back accepts with pending work give one event per cycle with no bubble.
- Latency: in_edge rises before posedge t → pending set at t → evt_valid/evt_id at t+1 if the port is free. Minimum 2 clock edges.
- Simultaneous events at one posedge, per channel i:
  - Edge on i, pending[i]=0: pending[i] <= 1.
  - Edge on i, pending[i]=1, i is winner this cycle: pending[i] stays 1 (new event). No overflow.
  - Edge on i, pending[i]=1, i not winner: event dropped, overflow[i] <= 1.
  - ovf_clr[i] together with a new overflow on i: set wins, overflow[i]=1.
- Presented event is not counted as pending: pending[i] may be 1 while evt_id==i is held. A further edge in that state overflows.
- pending is a registered output; overflow is a registered sticky bit.
- evt_ready while evt_valid=0 is ignored.
- Reset asserted mid-transfer discards the presented event and all pending state immediately.

Optional Feature:
- Macro EDGE_ARB_BOTH_EDGES_EN.
- Defined:
  - Falling edges (~in_edge & prev) also generate events.
  - Each pending slot stores polarity. Extra output evt_pol (1 bit; 1=rising, 0=falling) is presented with evt_id, follows the same hold rules, and resets to 0.
  - A second edge of either polarity while pending follows the same overflow rules; the stored polarity is the oldest one.
- Undefined: rising edges only; the evt_pol port does not exist.

Test Plan (N_CH=4):
- Reset then in_edge=4'b0000 → evt_valid=0, pending=0, overflow=0. Then in_edge[2] 0→1 before posedge t → pending=4'b0100 at t, evt_valid=1/evt_id=2/pending=0 at t+1.
- in_edge 0000→1111 in one cycle, evt_ready=1 → evt_id sequence 0,1,2,3 on 4 consecutive cycles, then evt_valid=0.
- Fairness: with last_grant=1, channels 0 and 3 pending → evt_id=3 first, then 0.
- Backpressure: evt_ready=0 with event ch1 presented → evt_id stays 1 for 5 cycles. Toggle in_edge[1] 0→1→0→1 → overflow[1]=1. ovf_clr[1]=1 for one cycle → overflow[1]=0.
- Grant-same-cycle: ch0 pending and winning while a new ch0 edge arrives → pending[0]=1 after the edge, overflow[0]=0, a second evt_id=0 follows.
- Assert reset while evt_valid=1 and ch0..ch2 pending → evt_valid, pending, overflow 0 immediately. After release with in_edge=4'b1000 held → one event, evt_id=3.
